// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the inter-stage pipeline registers: per-stage bundle widths,
// per-stage NOP control words and a small occupancy helper.
package pipe_stage_buf_pkg;

  // Control-bundle bit positions common to every stage that carries them.
  localparam int unsigned CtrlRegWriteBit = 0;
  localparam int unsigned CtrlMemWriteBit = 1;
  localparam int unsigned CtrlBranchBit   = 2;

  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IFID_CTRL_W  = 4;
  localparam int unsigned IDEX_DATA_W  = 64;
  localparam int unsigned IDEX_CTRL_W  = 12;
  localparam int unsigned EXMEM_DATA_W = 64;
  localparam int unsigned EXMEM_CTRL_W = 8;
  localparam int unsigned MEMWB_DATA_W = 64;
  localparam int unsigned MEMWB_CTRL_W = 4;

  // All-zero control words decode as NOP: reg_write, mem_write and branch off.
  localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_NOP  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_NOP  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = '0;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One pipeline entry: valid flag plus data/control bundles. Clearing restores the
// NOP control word and zero data so an empty entry is always safe to decode.
module pipe_stage_slot #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       CTRL_W   = 12,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_NOP;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_NOP;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
      ctrl  <= ld_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with valid/ready handshake, synchronous flush,
// optional skid entry (registered in_ready) and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       CTRL_W   = 12,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int unsigned       SKID     = 1,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_stage_buf_pkg::*;

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              accept_in, accept_out;
  logic              m_valid, m_load, m_clear, m_valid_d;
  logic [DATA_W-1:0] m_data, m_ld_data;
  logic [CTRL_W-1:0] m_ctrl, m_ld_ctrl;
  logic              s_valid, s_valid_d;
  logic [1:0]        occ_q;
  logic [CNT_W-1:0]  stall_q;

  assign accept_in  = in_valid & in_ready;
  assign accept_out = m_valid & out_ready;

  pipe_stage_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (m_load),
    .clear   (m_clear),
    .ld_data (m_ld_data),
    .ld_ctrl (m_ld_ctrl),
    .valid   (m_valid),
    .data    (m_data),
    .ctrl    (m_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              m_free, s_load, s_clear, rdy_q;
      logic [DATA_W-1:0] s_data;
      logic [CTRL_W-1:0] s_ctrl;

      // Main entry frees up this cycle: refill from skid first to keep arrival order.
      assign m_free    = ~m_valid | accept_out;
      assign in_ready  = rdy_q & ~flush;
      assign m_load    = ~flush & m_free & (s_valid | accept_in);
      assign m_clear   = flush | (m_free & ~s_valid & ~accept_in);
      assign m_ld_data = s_valid ? s_data : in_data;
      assign m_ld_ctrl = s_valid ? s_ctrl : in_ctrl;
      assign s_load    = ~flush & ~m_free & accept_in;
      assign s_clear   = flush | (m_free & s_valid);
      assign s_valid_d = s_clear ? 1'b0 : (s_load ? 1'b1 : s_valid);

      pipe_stage_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
      ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (s_load),
        .clear   (s_clear),
        .ld_data (in_data),
        .ld_ctrl (in_ctrl),
        .valid   (s_valid),
        .data    (s_data),
        .ctrl    (s_ctrl)
      );

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= ~s_valid_d;
        end
      end
    end else begin : g_single
      assign in_ready  = (~m_valid | out_ready) & ~flush;
      assign m_load    = accept_in;
      assign m_clear   = flush | (accept_out & ~accept_in);
      assign m_ld_data = in_data;
      assign m_ld_ctrl = in_ctrl;
      assign s_valid   = 1'b0;
      assign s_valid_d = 1'b0;
    end
  endgenerate

  assign m_valid_d = m_clear ? 1'b0 : (m_load ? 1'b1 : m_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= OccEmpty;
      stall_q <= '0;
    end else begin
      occ_q <= occ_count(m_valid_d, s_valid_d);
      if (m_valid && !out_ready && stall_q != CntMax) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a SKID=1/CNT_W=16 and a SKID=0/CNT_W=4 instance
// driven in turn; accepted beats are queued and a per-instance monitor checks the outputs.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [11:0] in_ctrl = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b1;

  logic        in_valid0, in_valid1, in_ready0, in_ready1, out_valid0, out_valid1;
  logic [63:0] out_data0, out_data1;
  logic [11:0] out_ctrl0, out_ctrl1;
  logic [1:0]  occupancy0, occupancy1;
  logic [3:0]  stall_cnt0;
  logic [15:0] stall_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [75:0] q0[$];
  logic [75:0] q1[$];
  int pop_cyc[$];

  assign in_valid0 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;

  logic        cur_ready, cur_valid;
  logic [63:0] cur_data;
  logic [11:0] cur_ctrl;
  int          cur_occ, cur_stall;
  assign cur_ready = sel ? in_ready1 : in_ready0;
  assign cur_valid = sel ? out_valid1 : out_valid0;
  assign cur_data  = sel ? out_data1 : out_data0;
  assign cur_ctrl  = sel ? out_ctrl1 : out_ctrl0;
  assign cur_occ   = sel ? int'(occupancy1) : int'(occupancy0);
  assign cur_stall = sel ? int'(stall_cnt1) : int'(stall_cnt0);

  pipe_stage_buf #(
    .DATA_W(64), .CTRL_W(12), .CTRL_NOP(12'h000), .SKID(1), .CNT_W(16)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
    .occupancy(occupancy1), .stall_cnt(stall_cnt1)
  );

  pipe_stage_buf #(
    .DATA_W(64), .CTRL_W(12), .CTRL_NOP(12'h000), .SKID(0), .CNT_W(4)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (sel=%0d) got %0d expected %0d", name, sel, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mk_ctrl(input logic [63:0] d);
    return {1'b1, d[10:0]};
  endfunction

  // Monitors: sample mid-cycle, pop on downstream accept, NOP/0 whenever invalid.
  always @(negedge clk) begin
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_beat got %h expected none", {out_ctrl1, out_data1});
      end else begin
        chk_beat("dut1_beat", {out_ctrl1, out_data1}, q1.pop_front());
        pop_cyc.push_back(cyc);
      end
    end else if (!out_valid1) begin
      chk_beat("dut1_idle_nop", {out_ctrl1, out_data1}, '0);
    end
  end

  always @(negedge clk) begin
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_beat got %h expected none", {out_ctrl0, out_data0});
      end else begin
        chk_beat("dut0_beat", {out_ctrl0, out_data0}, q0.pop_front());
        pop_cyc.push_back(cyc);
      end
    end else if (!out_valid0) begin
      chk_beat("dut0_idle_nop", {out_ctrl0, out_data0}, '0);
    end
  end

  // Called and returns at posedge+1; holds the beat until the selected DUT takes it.
  task automatic send(input logic [63:0] d);
    bit acc = 1'b0;
    int t = 0;
    in_data  = d;
    in_ctrl  = mk_ctrl(d);
    in_valid = 1'b1;
    do begin
      @(negedge clk); #1;
      acc = in_valid && cur_ready;
      if (acc) begin
        if (sel) q1.push_back({in_ctrl, in_data});
        else     q0.push_back({in_ctrl, in_data});
      end
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout (sel=%0d) beat %0d not accepted within 200 cycles", sel, d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      @(posedge clk); t++;
    end
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d/%0d beats left expected 0", q0.size(), q1.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic t_stream();
    int c0;
    out_ready = 1'b1;
    pop_cyc.delete();
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send(64'(i));
    drain();
    chk("stream_beats", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) begin
      chk("stream_latency", pop_cyc[0] - c0, 1);
      chk("stream_back_to_back", pop_cyc[7] - pop_cyc[0], 7);
    end
    chk("stream_stall_cnt", cur_stall, 0);
  endtask

  task automatic t_stall();
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 6; i++) send(64'(11 + i));
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_occupancy", cur_occ, sel ? 2 : 1);
        chk("stall_in_ready", int'(cur_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cnt_3", cur_stall, 3);
  endtask

  task automatic t_flush();
    int n;
    n = sel ? 2 : 1;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) send(64'(41 + i));
    chk("flush_pre_occupancy", cur_occ, n);
    in_data  = 64'd50;
    in_ctrl  = mk_ctrl(64'd50);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", int'(cur_ready), 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q0.delete();
    q1.delete();
    chk("flush_out_valid", int'(cur_valid), 0);
    chk("flush_out_ctrl", int'(cur_ctrl), 0);
    chk("flush_out_data", int'(cur_data[31:0]), 0);
    chk("flush_occupancy", cur_occ, 0);
    drain();
  endtask

  task automatic t_reset();
    out_ready = 1'b0;
    send(64'd61);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(cur_valid), 0);
    chk("arst_out_ctrl", int'(cur_ctrl), 0);
    chk("arst_out_data", int'(cur_data[31:0]), 0);
    chk("arst_occupancy", cur_occ, 0);
    chk("arst_stall_cnt", cur_stall, 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready_after", int'(cur_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(64'(71 + i));
    drain();
  endtask

  task automatic t_saturate();
    out_ready = 1'b0;
    send(64'd81);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_cnt_20", cur_stall, sel ? 20 : 15);
    drain();
  endtask

  task automatic t_random();
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(64'(100 + i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
      end
    join
    drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready1", int'(in_ready1), 1);
    chk("rst_in_ready0", int'(in_ready0), 1);
    chk("rst_occupancy1", int'(occupancy1), 0);
    chk("rst_stall_cnt1", int'(stall_cnt1), 0);
    for (int s = 1; s >= 0; s--) begin
      sel = (s == 1);
      t_stream();
      t_stall();
      t_flush();
      t_reset();
      t_saturate();
      t_random();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
